// File: rtl/pararam_arbiter.sv
// pararam_arbiter: round-robin arbiter sequencing Wishbone and host-port accesses onto one single-port SRAM
module pararam_arbiter #(
  parameter int ADDR_W = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              p1_req_i,
  input  logic              p1_we_i,
  input  logic [3:0]        p1_sel_i,
  input  logic [ADDR_W-1:0] p1_adr_i,
  input  logic [31:0]       p1_dat_i,
  output logic              p1_ack_o,
  output logic [31:0]       p1_dat_o,
  output logic              ram_csb_o,
  output logic              ram_web_o,
  output logic [3:0]        ram_wmask_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_din_o,
  input  logic [31:0]       ram_dout_i
);
  typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;
  state_t r_state, w_next;
  logic r_prio, r_port, r_we, r_abort, r_csb, r_web;
  logic [3:0] r_wmask;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0] r_din;
  logic w_req0, w_req1, w_gnt1, w_we, w_ack0, w_ack1, w_unused;
  logic [3:0] w_sel;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0] w_dat;
  assign w_req0 = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign w_req1 = p1_req_i;
  assign w_gnt1 = w_req1 & (~w_req0 | r_prio);
  assign w_we   = w_gnt1 ? p1_we_i : wbs_we_i;
  assign w_sel  = w_gnt1 ? p1_sel_i : wbs_sel_i;
  assign w_addr = w_gnt1 ? p1_adr_i : wbs_adr_i[ADDR_W+1:2];
  assign w_dat  = w_gnt1 ? p1_dat_i : wbs_dat_i;
  assign w_unused = ^wbs_adr_i[1:0];
  assign w_ack0 = (r_state == RESP) & ~r_port & wbs_cyc_i & ~r_abort;
  assign w_ack1 = (r_state == RESP) & r_port;
  assign wbs_ack_o = w_ack0;
  assign p1_ack_o  = w_ack1;
  assign wbs_dat_o = (w_ack0 & ~r_we) ? ram_dout_i : 32'h0;
  assign p1_dat_o  = (w_ack1 & ~r_we) ? ram_dout_i : 32'h0;
  // a reset arriving during the command cycle must keep the SRAM from latching it
  assign ram_csb_o   = r_csb | wb_rst_i;
  assign ram_web_o   = r_web | wb_rst_i;
  assign ram_wmask_o = wb_rst_i ? 4'h0 : r_wmask;
  assign ram_addr_o  = r_addr;
  assign ram_din_o   = r_din;
  // state register
  always_ff @(posedge wb_clk_i) r_state <= wb_rst_i ? IDLE : w_next;
  // next state: one command cycle and one response cycle per grant
  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE && (w_req0 | w_req1)) w_next = CMD;
    else if (r_state == CMD) w_next = RESP;
  end
  // grant capture, alternating priority and registered SRAM command
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_prio  <= 1'b0;
      r_port  <= 1'b0;
      r_we    <= 1'b0;
      r_abort <= 1'b0;
      r_csb   <= 1'b1;
      r_web   <= 1'b1;
      r_wmask <= 4'h0;
      r_addr  <= '0;
      r_din   <= 32'h0;
    end else if (r_state == IDLE) begin
      if (w_req0 | w_req1) begin
        r_port  <= w_gnt1;
        r_prio  <= ~w_gnt1;
        r_we    <= w_we;
        r_abort <= 1'b0;
        r_csb   <= 1'b0;
        r_web   <= ~w_we;
        r_wmask <= w_we ? w_sel : 4'h0;
        r_addr  <= w_addr;
        if (w_we) r_din <= w_dat;
      end
    end else if (r_state == CMD) begin
      r_csb   <= 1'b1;
      r_web   <= 1'b1;
      r_wmask <= 4'h0;
      if (~r_port & ~wbs_cyc_i) r_abort <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pararam_arbiter.sv
// tb_pararam_arbiter: scoreboard bench for the ParaRAM arbiter with a behavioural SRAM
module tb_pararam_arbiter;
  logic clk = 1'b0, rst = 1'b1, mon_en = 1'b0, mem_clr = 1'b1;
  logic wbs_stb = 0, wbs_cyc = 0, wbs_we = 0;
  logic [3:0] wbs_sel = 0;
  logic [31:0] wbs_adr = 0, wbs_dat = 0;
  logic wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic p1_req = 0, p1_we = 0;
  logic [3:0] p1_sel = 0;
  logic [7:0] p1_adr = 0;
  logic [31:0] p1_dat = 0;
  logic p1_ack_o;
  logic [31:0] p1_dat_o;
  logic ram_csb_o, ram_web_o;
  logic [3:0] ram_wmask_o;
  logic [7:0] ram_addr_o;
  logic [31:0] ram_din_o, ram_dout = 0;
  logic [31:0] mem [256];
  int checks = 0, failures = 0, cyc = 0, k = 0;
  typedef struct {logic port; logic [31:0] dat; int t;} ack_t;
  typedef struct {logic we; logic [3:0] m; logic [7:0] a; logic [31:0] d;} cmd_t;
  ack_t aq[$];
  cmd_t cq[$];
  ack_t ea;
  cmd_t ec;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pararam_arbiter dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(wbs_stb), .wbs_cyc_i(wbs_cyc), .wbs_we_i(wbs_we), .wbs_sel_i(wbs_sel),
    .wbs_adr_i(wbs_adr), .wbs_dat_i(wbs_dat), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_sel_i(p1_sel), .p1_adr_i(p1_adr), .p1_dat_i(p1_dat),
    .p1_ack_o(p1_ack_o), .p1_dat_o(p1_dat_o),
    .ram_csb_o(ram_csb_o), .ram_web_o(ram_web_o), .ram_wmask_o(ram_wmask_o),
    .ram_addr_o(ram_addr_o), .ram_din_o(ram_din_o), .ram_dout_i(ram_dout)
  );

  // behavioural SRAM: command sampled on the edge, read data the following cycle
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= {4{i[7:0]}};
    end else if (!ram_csb_o) begin
      if (!ram_web_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_wmask_o[b]) mem[ram_addr_o][b*8 +: 8] <= ram_din_o[b*8 +: 8];
      end else ram_dout <= mem[ram_addr_o];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: pops expected acks and SRAM commands whenever the DUT presents them
  always @(negedge clk) begin
    if (mon_en) begin
      if (!wbs_ack_o) chk("wb_dat_idle", wbs_dat_o, 32'h0);
      if (!p1_ack_o) chk("p1_dat_idle", p1_dat_o, 32'h0);
      if (wbs_ack_o || p1_ack_o) begin
        if (aq.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_ack: wb=%b p1=%b at cycle %0d", wbs_ack_o, p1_ack_o, cyc);
        end else begin
          ea = aq.pop_front();
          chk("ack_port", {31'b0, p1_ack_o}, {31'b0, ea.port});
          chk("ack_both", {31'b0, wbs_ack_o & p1_ack_o}, 32'h0);
          chk("ack_dat", p1_ack_o ? p1_dat_o : wbs_dat_o, ea.dat);
          chk("ack_cycle", 32'(cyc), 32'(ea.t));
        end
      end
      if (!ram_csb_o) begin
        if (cq.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_cmd: addr=%h at cycle %0d", ram_addr_o, cyc);
        end else begin
          ec = cq.pop_front();
          chk("cmd_we", {31'b0, !ram_web_o}, {31'b0, ec.we});
          chk("cmd_wmask", {28'b0, ram_wmask_o}, {28'b0, ec.m});
          chk("cmd_addr", {24'b0, ram_addr_o}, {24'b0, ec.a});
          if (ec.we) chk("cmd_din", ram_din_o, ec.d);
        end
      end
    end
  end

  task automatic wb_req(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic got = 1'b0;
    wbs_cyc = 1; wbs_stb = 1; wbs_we = we; wbs_adr = adr; wbs_dat = dat; wbs_sel = sel;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = wbs_ack_o;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL wb_timeout: got no ack expected ack for adr %h", adr);
    end
    @(posedge clk); #1;
    wbs_cyc = 0; wbs_stb = 0; wbs_we = 0;
  endtask

  task automatic p1_rq(input logic we, input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic got = 1'b0;
    p1_req = 1; p1_we = we; p1_adr = adr; p1_dat = dat; p1_sel = sel;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = p1_ack_o;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL p1_timeout: got no ack expected ack for adr %h", adr);
    end
    @(posedge clk); #1;
    p1_req = 0; p1_we = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0; mem_clr = 0;
    @(negedge clk);
    chk("rst_csb", {31'b0, ram_csb_o}, 32'h1);
    chk("rst_web", {31'b0, ram_web_o}, 32'h1);
    chk("rst_wmask", {28'b0, ram_wmask_o}, 32'h0);
    chk("rst_addr", {24'b0, ram_addr_o}, 32'h0);
    chk("rst_din", ram_din_o, 32'h0);
    chk("rst_acks", {30'b0, wbs_ack_o, p1_ack_o}, 32'h0);
    mon_en = 1;
    @(posedge clk); #1;
    // WB write then WB read of word 4
    k = cyc;
    cq.push_back(cmd_t'{1'b1, 4'hF, 8'd4, 32'hDEADBEEF});
    aq.push_back(ack_t'{1'b0, 32'h0, k + 2});
    wb_req(1, 32'h3000_0010, 32'hDEADBEEF, 4'hF);
    k = cyc;
    cq.push_back(cmd_t'{1'b0, 4'h0, 8'd4, 32'h0});
    aq.push_back(ack_t'{1'b0, 32'hDEADBEEF, k + 2});
    wb_req(0, 32'h3000_0010, 32'h0, 4'hF);
    // reset during the command cycle of a write to word 9
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 1; wbs_adr = 32'h3000_0024; wbs_dat = 32'hCAFEF00D; wbs_sel = 4'hF;
    @(posedge clk); #1;
    rst = 1; wbs_cyc = 0; wbs_stb = 0; wbs_we = 0;
    @(negedge clk);
    chk("rst_cmd_csb", {31'b0, ram_csb_o}, 32'h1);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst2_csb", {31'b0, ram_csb_o}, 32'h1);
    chk("rst2_wmask", {28'b0, ram_wmask_o}, 32'h0);
    chk("rst2_addr", {24'b0, ram_addr_o}, 32'h0);
    chk("rst2_din", ram_din_o, 32'h0);
    chk("rst2_acks", {30'b0, wbs_ack_o, p1_ack_o}, 32'h0);
    @(posedge clk); #1;
    // simultaneous after reset: port 0 first; word 9 still holds its old value
    k = cyc;
    cq.push_back(cmd_t'{1'b0, 4'h0, 8'd9, 32'h0});
    cq.push_back(cmd_t'{1'b0, 4'h0, 8'd5, 32'h0});
    aq.push_back(ack_t'{1'b0, 32'h09090909, k + 2});
    aq.push_back(ack_t'{1'b1, 32'h05050505, k + 5});
    fork
      wb_req(0, 32'h3000_0024, 32'h0, 4'hF);
      p1_rq(0, 8'd5, 32'h0, 4'hF);
    join
    // lone WB access hands priority to port 1
    k = cyc;
    cq.push_back(cmd_t'{1'b0, 4'h0, 8'd4, 32'h0});
    aq.push_back(ack_t'{1'b0, 32'hDEADBEEF, k + 2});
    wb_req(0, 32'h3000_0010, 32'h0, 4'hF);
    k = cyc;
    cq.push_back(cmd_t'{1'b0, 4'h0, 8'd5, 32'h0});
    cq.push_back(cmd_t'{1'b0, 4'h0, 8'd9, 32'h0});
    aq.push_back(ack_t'{1'b1, 32'h05050505, k + 2});
    aq.push_back(ack_t'{1'b0, 32'h09090909, k + 5});
    fork
      wb_req(0, 32'h3000_0024, 32'h0, 4'hF);
      p1_rq(0, 8'd5, 32'h0, 4'hF);
    join
    // host byte-masked write and read-back
    k = cyc;
    cq.push_back(cmd_t'{1'b1, 4'b0010, 8'd7, 32'h0000AB00});
    aq.push_back(ack_t'{1'b1, 32'h0, k + 2});
    p1_rq(1, 8'd7, 32'h0000AB00, 4'b0010);
    k = cyc;
    cq.push_back(cmd_t'{1'b0, 4'h0, 8'd7, 32'h0});
    aq.push_back(ack_t'{1'b1, 32'h0707AB07, k + 2});
    p1_rq(0, 8'd7, 32'h0, 4'h0);
    // Wishbone abort during command: write committed, no ack, host served next
    k = cyc;
    cq.push_back(cmd_t'{1'b1, 4'hF, 8'd3, 32'h12345678});
    cq.push_back(cmd_t'{1'b0, 4'h0, 8'd3, 32'h0});
    aq.push_back(ack_t'{1'b1, 32'h12345678, k + 5});
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 1; wbs_adr = 32'h3000_000C; wbs_dat = 32'h12345678; wbs_sel = 4'hF;
    fork
      p1_rq(0, 8'd3, 32'h0, 4'h0);
      begin
        @(posedge clk); #1;
        wbs_cyc = 0; wbs_stb = 0; wbs_we = 0;
      end
    join
    // out-of-window Wishbone cycle is ignored
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 0; wbs_adr = 32'h2000_0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("oow_csb", {31'b0, ram_csb_o}, 32'h1);
      chk("oow_ack", {31'b0, wbs_ack_o}, 32'h0);
    end
    @(posedge clk); #1;
    wbs_cyc = 0; wbs_stb = 0;
    repeat (3) @(negedge clk);
    chk("ack_queue_empty", 32'(aq.size()), 32'h0);
    chk("cmd_queue_empty", 32'(cq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
